// File: rtl/rv_datapath_param.sv
`default_nettype none
// ============================================================================
// rv_datapath_param : parametrised multicycle RISC-V datapath (XLEN / NREG)
// Revision 1.0
// ============================================================================
module rv_datapath_param #(
   parameter int              XLEN     = 32,
   parameter int              NREG     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      imm_src,
   input  logic [3:0]      alu_ctrl,
   input  logic [1:0]      result_src,
   input  logic [1:0]      alu_src_a,
   input  logic [1:0]      alu_src_b,
   input  logic            ir_write,
   input  logic            reg_write,
   input  logic            pc_write,
   input  logic            addr_src,
   input  logic            jalr_lsb,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic [XLEN-1:0] addr,
   output logic [XLEN-1:0] wdata,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] alu_out,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] imm_ext,
   output logic            zero,
   output logic            cout,
   output logic            alu_msb,
   output logic            ill_reg
);

   localparam int         RIDX_W  = $clog2(NREG);
   localparam int         SHAMT_W = $clog2(XLEN);
   localparam logic [5:0] NREG_6  = 6'(NREG);

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLL   = 4'b0101;
   localparam logic [3:0] ALU_SRL   = 4'b0110;
   localparam logic [3:0] ALU_SRA   = 4'b0111;
   localparam logic [3:0] ALU_SLT   = 4'b1000;
   localparam logic [3:0] ALU_SLTU  = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] old_pc_q, old_pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] data_reg_q, data_reg_d;
   logic [XLEN-1:0] a_reg_q, a_reg_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] alu_out_q, alu_out_d;
   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];

   logic [4:0]         rs1, rs2, rd;
   logic               rs1_ok, rs2_ok, rd_ok;
   logic [XLEN-1:0]    rd1, rd2;
   logic [31:0]        imm32;
   logic [XLEN-1:0]    src_a, src_b, alu_raw;
   logic [XLEN:0]      sum_ext, dif_ext;
   logic [SHAMT_W-1:0] shamt;
   logic               carry;

   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];
   assign rd     = instr_q[11:7];
   assign rs1_ok = ({1'b0, rs1} < NREG_6);
   assign rs2_ok = ({1'b0, rs2} < NREG_6);
   assign rd_ok  = ({1'b0, rd} < NREG_6);

   // x0 and out-of-range indices read as zero regardless of array contents
   assign rd1 = (rs1_ok && rs1 != 5'd0) ? rf_q[rs1[RIDX_W-1:0]] : '0;
   assign rd2 = (rs2_ok && rs2 != 5'd0) ? rf_q[rs2[RIDX_W-1:0]] : '0;

   always_comb begin
      imm32 = '0;
      case (imm_src)
         3'b000: imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
         3'b001: imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
         3'b010: imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
         3'b011: imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                          instr_q[20], instr_q[30:21], 1'b0};
         3'b100: imm32 = {instr_q[31:12], 12'b0};
         default: imm32 = '0;
      endcase
      imm_ext = XLEN'($signed(imm32));
   end

   always_comb begin
      src_a = '0;
      case (alu_src_a)
         2'b00:   src_a = pc_q;
         2'b01:   src_a = old_pc_q;
         2'b10:   src_a = a_reg_q;
         default: src_a = '0;
      endcase
      src_b = '0;
      case (alu_src_b)
         2'b00:   src_b = wdata_q;
         2'b01:   src_b = imm_ext;
         2'b10:   src_b = XLEN'(4);
         default: src_b = '0;
      endcase
   end

   // Subtraction as A + ~B + 1 so the top carry is directly NOT borrow
   always_comb begin
      sum_ext = {1'b0, src_a} + {1'b0, src_b};
      dif_ext = {1'b0, src_a} + {1'b0, ~src_b} + {{XLEN{1'b0}}, 1'b1};
      shamt   = src_b[SHAMT_W-1:0];
      alu_raw = '0;
      carry   = 1'b0;
      case (alu_ctrl)
         ALU_ADD: begin
            alu_raw = sum_ext[XLEN-1:0];
            carry   = sum_ext[XLEN];
         end
         ALU_SUB: begin
            alu_raw = dif_ext[XLEN-1:0];
            carry   = dif_ext[XLEN];
         end
         ALU_AND:   alu_raw = src_a & src_b;
         ALU_OR:    alu_raw = src_a | src_b;
         ALU_XOR:   alu_raw = src_a ^ src_b;
         ALU_SLL:   alu_raw = src_a << shamt;
         ALU_SRL:   alu_raw = src_a >> shamt;
         ALU_SRA:   alu_raw = $unsigned($signed(src_a) >>> shamt);
         ALU_SLT:   alu_raw = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         ALU_SLTU:  alu_raw = {{(XLEN-1){1'b0}}, src_a < src_b};
         ALU_PASSB: alu_raw = src_b;
         default:   alu_raw = '0;
      endcase
      alu_result = alu_raw & ~{{(XLEN-1){1'b0}}, jalr_lsb};
   end

   assign zero    = (alu_result == '0);
   assign alu_msb = alu_result[XLEN-1];
   assign cout    = carry;

   always_comb begin
      result = '0;
      case (result_src)
         2'b00:   result = alu_out_q;
         2'b01:   result = data_reg_q;
         2'b10:   result = alu_result;
         default: result = imm_ext;
      endcase
   end

   assign addr = addr_src ? result : pc_q;

   // mem_ready low freezes every state element, register file included
   always_comb begin
      pc_d       = pc_q;
      old_pc_d   = old_pc_q;
      instr_d    = instr_q;
      data_reg_d = data_reg_q;
      a_reg_d    = a_reg_q;
      wdata_d    = wdata_q;
      alu_out_d  = alu_out_q;
      rf_d       = rf_q;
      if (mem_ready) begin
         if (pc_write) pc_d = result;
         if (ir_write) begin
            old_pc_d = pc_q;
            instr_d  = mem_rdata[31:0];
         end
         data_reg_d = mem_rdata;
         a_reg_d    = rd1;
         wdata_d    = rd2;
         alu_out_d  = alu_result;
         if (reg_write && rd_ok && rd != 5'd0) rf_d[rd[RIDX_W-1:0]] = result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         old_pc_q   <= '0;
         instr_q    <= '0;
         data_reg_q <= '0;
         a_reg_q    <= '0;
         wdata_q    <= '0;
         alu_out_q  <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         pc_q       <= pc_d;
         old_pc_q   <= old_pc_d;
         instr_q    <= instr_d;
         data_reg_q <= data_reg_d;
         a_reg_q    <= a_reg_d;
         wdata_q    <= wdata_d;
         alu_out_q  <= alu_out_d;
         rf_q       <= rf_d;
      end
   end

   assign pc      = pc_q;
   assign instr   = instr_q;
   assign wdata   = wdata_q;
   assign alu_out = alu_out_q;
   assign ill_reg = ~rs1_ok | ~rs2_ok | ~rd_ok;

endmodule
`default_nettype wire

// File: tb/tb_rv_datapath_param.sv
`default_nettype none
// ============================================================================
// tb_rv_datapath_param : directed bench with an architectural reference model
// Revision 1.0
// ============================================================================
module tb_rv_datapath_param;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  imm_src;
   logic [3:0]  alu_ctrl;
   logic [1:0]  result_src, alu_src_a, alu_src_b;
   logic        ir_write, reg_write, pc_write, addr_src, jalr_lsb, mem_ready;
   logic [63:0] mem_rdata;
   logic [63:0] addr, wdata, pc, result, alu_out, alu_result, imm_ext;
   logic [31:0] instr;
   logic        zero, cout, alu_msb, ill_reg;

   rv_datapath_param #(.XLEN(64), .NREG(16), .RESET_PC(64'h100)) dut (
      .clk(clk), .rst(rst), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .ir_write(ir_write), .reg_write(reg_write), .pc_write(pc_write),
      .addr_src(addr_src), .jalr_lsb(jalr_lsb), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .addr(addr), .wdata(wdata), .instr(instr),
      .pc(pc), .result(result), .alu_out(alu_out), .alu_result(alu_result),
      .imm_ext(imm_ext), .zero(zero), .cout(cout), .alu_msb(alu_msb),
      .ill_reg(ill_reg)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic chk_on = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- architectural reference model ----------------
   typedef struct packed {
      logic [63:0] imm, ar, res, ad;
      logic        z, c, msb, ill;
   } ev_t;

   logic [63:0] m_pc, m_old, m_data, m_a, m_wd, m_alu_out;
   logic [31:0] m_instr;
   logic [63:0] m_rf [16];
   ev_t         m_now;

   function automatic logic [63:0] f_imm(input logic [31:0] i, input logic [2:0] s);
      longint      sx;
      logic [63:0] r;
      sx = longint'($signed(i));
      r  = '0;
      case (s)
         3'd0: begin sx = sx >>> 20; r = sx; end
         3'd1: begin sx = sx >>> 25; r = sx; r = (r << 5) | 64'(i[11:7]); end
         3'd2: begin
            sx = sx >>> 31; r = sx;
            r = (r << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
         end
         3'd3: begin
            sx = sx >>> 31; r = sx;
            r = (r << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
         end
         3'd4: begin r = sx; r = r & ~64'hFFF; end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [64:0] f_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      logic        c;
      r = '0;
      c = 1'b0;
      case (op)
         4'd0:  begin r = a + b; c = (r < a); end
         4'd1:  begin r = a - b; c = (a >= b); end
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = a << b[5:0];
         4'd6:  r = a >> b[5:0];
         4'd7:  r = $signed(a) >>> b[5:0];
         4'd8:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4'd9:  r = (a < b) ? 64'd1 : 64'd0;
         4'd10: r = b;
         default: r = '0;
      endcase
      return {c, r};
   endfunction

   function automatic logic [63:0] m_rd(input logic [4:0] ix);
      return (ix != 5'd0 && ix < 5'd16) ? m_rf[ix[3:0]] : 64'd0;
   endfunction

   function automatic ev_t f_eval();
      ev_t         e;
      logic [63:0] a, b;
      logic [64:0] cr;
      e.imm = f_imm(m_instr, imm_src);
      case (alu_src_a)
         2'd0: a = m_pc;
         2'd1: a = m_old;
         2'd2: a = m_a;
         default: a = '0;
      endcase
      case (alu_src_b)
         2'd0: b = m_wd;
         2'd1: b = e.imm;
         2'd2: b = 64'd4;
         default: b = '0;
      endcase
      cr   = f_alu(alu_ctrl, a, b);
      e.ar = cr[63:0];
      if (jalr_lsb) e.ar[0] = 1'b0;
      e.c   = cr[64];
      e.z   = (e.ar == 64'd0);
      e.msb = e.ar[63];
      case (result_src)
         2'd0: e.res = m_alu_out;
         2'd1: e.res = m_data;
         2'd2: e.res = e.ar;
         default: e.res = e.imm;
      endcase
      e.ad  = addr_src ? e.res : m_pc;
      e.ill = (m_instr[19:15] >= 5'd16) || (m_instr[24:20] >= 5'd16) || (m_instr[11:7] >= 5'd16);
      return e;
   endfunction

   always_comb m_now = f_eval();

   always @(posedge clk) begin
      if (rst) begin
         m_pc <= 64'h100; m_old <= '0; m_instr <= '0; m_data <= '0;
         m_a <= '0; m_wd <= '0; m_alu_out <= '0;
         for (int k = 0; k < 16; k++) m_rf[k] <= '0;
      end else if (mem_ready) begin
         if (reg_write && m_instr[11:7] != 5'd0 && m_instr[11:7] < 5'd16)
            m_rf[m_instr[10:7]] <= m_now.res;
         if (pc_write) m_pc <= m_now.res;
         if (ir_write) begin
            m_old   <= m_pc;
            m_instr <= mem_rdata[31:0];
         end
         m_data    <= mem_rdata;
         m_a       <= m_rd(m_instr[19:15]);
         m_wd      <= m_rd(m_instr[24:20]);
         m_alu_out <= m_now.ar;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("pc", pc, m_pc);
         chk("instr", {32'd0, instr}, {32'd0, m_instr});
         chk("wdata", wdata, m_wd);
         chk("alu_out", alu_out, m_alu_out);
         chk("imm_ext", imm_ext, m_now.imm);
         chk("alu_result", alu_result, m_now.ar);
         chk("result", result, m_now.res);
         chk("addr", addr, m_now.ad);
         chk("zero", {63'd0, zero}, {63'd0, m_now.z});
         chk("cout", {63'd0, cout}, {63'd0, m_now.c});
         chk("alu_msb", {63'd0, alu_msb}, {63'd0, m_now.msb});
         chk("ill_reg", {63'd0, ill_reg}, {63'd0, m_now.ill});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_idle();
      imm_src = 3'd0; alu_ctrl = 4'd0; result_src = 2'd0;
      alu_src_a = 2'd0; alu_src_b = 2'd0;
      ir_write = 1'b0; reg_write = 1'b0; pc_write = 1'b0;
      addr_src = 1'b0; jalr_lsb = 1'b0; mem_ready = 1'b1;
   endtask

   // Fetch an instruction word, then one more edge so a_reg/wdata hold its operands
   task automatic load(input logic [31:0] w);
      mem_rdata = {32'd0, w};
      ir_write  = 1'b1;
      tick();
      ir_write  = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      mem_rdata = '0;
      set_idle();
      tick();
      chk_on = 1'b1;
      chk("rst_pc", pc, 64'h100);
      chk("rst_instr", {32'd0, instr}, 64'd0);
      chk("rst_addr", addr, 64'h100);
      chk("rst_ill", {63'd0, ill_reg}, 64'd0);
      chk("rst_wdata", wdata, 64'd0);
      chk("rst_alu_out", alu_out, 64'd0);
      rst = 1'b0;

      for (int i = 1; i < 32; i++) begin
         load({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h13});
         chk("rd_zero_b", wdata, 64'd0);
         alu_src_a = 2'd2; alu_src_b = 2'd3; result_src = 2'd2;
         #1;
         chk("rd_zero_a", alu_result, 64'd0);
         set_idle();
      end

      // fetch under a 3-cycle stall
      mem_rdata = 64'h00500093;
      ir_write = 1'b1; pc_write = 1'b1; alu_src_a = 2'd0; alu_src_b = 2'd2;
      alu_ctrl = 4'd0; result_src = 2'd2; mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_pc", pc, 64'h100);
         chk("stall_instr", {32'd0, instr}, 64'h01FF8013);
         chk("stall_result", result, 64'h104);
      end
      mem_ready = 1'b1;
      tick();
      chk("fetch_pc", pc, 64'h104);
      chk("fetch_instr", {32'd0, instr}, 64'h00500093);
      set_idle();
      alu_src_a = 2'd1; alu_src_b = 2'd3;
      #1;
      chk("fetch_old_pc", alu_result, 64'h100);
      set_idle();

      // execute addi x1,x0,5 and write back
      tick();
      alu_src_a = 2'd2; alu_src_b = 2'd1;
      #1;
      chk("addi_alu", alu_result, 64'd5);
      tick();
      chk("addi_alu_out", alu_out, 64'd5);
      result_src = 2'd0; reg_write = 1'b1;
      #1;
      chk("addi_result", result, 64'd5);
      tick();
      set_idle();
      load(32'h00108133);
      chk("x1_eq_5", wdata, 64'd5);

      // same sequence targeting x0
      load(32'h00500013);
      alu_src_a = 2'd2; alu_src_b = 2'd1;
      tick();
      chk("x0_alu_out", alu_out, 64'd5);
      reg_write = 1'b1;
      tick();
      set_idle();
      load(32'h00000033);
      chk("x0_stays_0", wdata, 64'd0);

      // x1 = -1 through the immediate result path, then shifts by 4
      load(32'hFFF00093);
      result_src = 2'd3; reg_write = 1'b1;
      #1;
      chk("imm_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      set_idle();
      load(32'h0040D113);
      alu_src_a = 2'd2; alu_src_b = 2'd1; alu_ctrl = 4'd7;
      #1;
      chk("sra4", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("sra_msb", {63'd0, alu_msb}, 64'd1);
      alu_ctrl = 4'd6;
      #1;
      chk("srl4", alu_result, 64'h0FFF_FFFF_FFFF_FFFF);
      chk("srl_msb", {63'd0, alu_msb}, 64'd0);
      chk("srl_cout", {63'd0, cout}, 64'd0);
      set_idle();

      // x3 = 5; sub 5-5, sll, then x1 (-1) against x3
      load(32'h00500193);
      result_src = 2'd3; reg_write = 1'b1;
      tick();
      set_idle();
      load(32'h00318233);
      alu_src_a = 2'd2; alu_src_b = 2'd0; alu_ctrl = 4'd1;
      #1;
      chk("sub_res", alu_result, 64'd0);
      chk("sub_zero", {63'd0, zero}, 64'd1);
      chk("sub_cout", {63'd0, cout}, 64'd1);
      alu_ctrl = 4'd5;
      #1;
      chk("sll", alu_result, 64'hA0);
      set_idle();
      load(32'h00308233);
      alu_src_a = 2'd2; alu_src_b = 2'd0; alu_ctrl = 4'd0;
      #1;
      chk("add_wrap", alu_result, 64'd4);
      chk("add_cout", {63'd0, cout}, 64'd1);
      alu_ctrl = 4'd8;
      #1;
      chk("slt", alu_result, 64'd1);
      alu_ctrl = 4'd9;
      #1;
      chk("sltu", alu_result, 64'd0);
      set_idle();

      // jalr through x5 = 0x203
      load(32'h20300293);
      result_src = 2'd3; reg_write = 1'b1;
      tick();
      set_idle();
      load(32'h00028067);
      alu_src_a = 2'd2; alu_src_b = 2'd1; jalr_lsb = 1'b1;
      result_src = 2'd2; pc_write = 1'b1;
      #1;
      chk("jalr_alu", alu_result, 64'h202);
      addr_src = 1'b1;
      #1;
      chk("jalr_addr", addr, 64'h202);
      tick();
      set_idle();
      chk("jalr_pc", pc, 64'h202);

      // rd = x17 is out of range: flagged and not written
      load(32'h123458B7);
      chk("ill_rd17", {63'd0, ill_reg}, 64'd1);
      imm_src = 3'd4; result_src = 2'd3;
      #1;
      chk("lui_result", result, 64'h12345000);
      reg_write = 1'b1;
      tick();
      set_idle();
      load(32'h00108133);
      chk("x1_untouched", wdata, 64'hFFFF_FFFF_FFFF_FFFF);

      // immediate formats
      load(32'h800000B7);
      imm_src = 3'd4;
      #1;
      chk("u_neg", imm_ext, 64'hFFFF_FFFF_8000_0000);
      load(32'hFFDFF06F);
      imm_src = 3'd3;
      #1;
      chk("j_m4", imm_ext, 64'hFFFF_FFFF_FFFF_FFFC);
      load(32'hFE000EE3);
      imm_src = 3'd2;
      #1;
      chk("b_m4", imm_ext, 64'hFFFF_FFFF_FFFF_FFFC);
      set_idle();
      load(32'hF5A5C4E3);
      mem_ready = 1'b0;
      for (int s = 0; s < 8; s++) begin
         imm_src = 3'(s);
         tick();
      end
      set_idle();

      // data register path
      mem_rdata = 64'hDEADBEEF_CAFEF00D;
      tick();
      result_src = 2'd1;
      #1;
      chk("data_reg", result, 64'hDEADBEEF_CAFEF00D);

      // reset mid-instruction overrides stall and enables
      ir_write = 1'b1; pc_write = 1'b1; reg_write = 1'b1; mem_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_idle();
      chk("mid_rst_pc", pc, 64'h100);
      chk("mid_rst_instr", {32'd0, instr}, 64'd0);
      chk("mid_rst_addr", addr, 64'h100);
      load(32'h00108133);
      chk("mid_rst_x1", wdata, 64'd0);

      tick();
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
